// File: rtl/instr_enc_if.sv
// Field-set and instruction-memory bus for the instruction encoder.
// Combinational bundle only; no storage, no latency.
// Backpressure: fld_rdy throttles the field producer, im_rdy throttles the encoder.
interface instr_enc_if;
    logic        fld_vld;
    logic        fld_rdy;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [8:0]  imm;
    logic [2:0]  cond;
    logic        im_we;
    logic        im_rdy;
    logic [15:0] im_addr;
    logic [15:0] im_wdata;

    // Producer / memory side: drives field sets and memory ready.
    modport master (
        output fld_vld, op, rd, rs, rt, imm, cond, im_rdy,
        input  fld_rdy, im_we, im_addr, im_wdata
    );

    // Encoder side.
    modport slave (
        input  fld_vld, op, rd, rs, rt, imm, cond, im_rdy,
        output fld_rdy, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/instr_enc.sv
// Packs instruction field sets into 16-bit words and streams them to instruction memory.
// Latency: a pushed word is offered on im_we the cycle after it is accepted (4-entry FIFO).
// Backpressure: fld_rdy low when FIFO full (unless a retire frees a slot) or not RUN; im_rdy stalls retirement.
// Optional: define INSTR_ENC_CHK_EN to reject undefined opcodes (set err, drop word).
module instr_enc (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [15:0]  base,
    instr_enc_if.slave   bus,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [15:0]  count
);
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDZ = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_LHB  = 4'hA;
    localparam logic [3:0] OP_LLB  = 4'hB;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] fifo_mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  fifo_cnt;
    logic [15:0] im_addr_q;
    logic [15:0] count_q;
    logic        err_q;
    logic [15:0] word;
    logic        legal;
    logic        fifo_empty, fifo_full;
    logic        accept, push, pop, load;

    assign fifo_empty = (fifo_cnt == 3'd0);
    assign fifo_full  = (fifo_cnt == 3'd4);

    assign bus.im_we    = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !fifo_empty;
    assign pop          = bus.im_we && bus.im_rdy;
    // A full FIFO still takes a field set when its head retires in the same cycle.
    assign bus.fld_rdy  = (state_q == S_RUN) && (!fifo_full || bus.im_rdy);
    assign accept       = bus.fld_vld && bus.fld_rdy;
    assign push         = accept && legal;
    assign load         = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign bus.im_wdata = bus.im_we ? fifo_mem[rd_ptr] : 16'h0000;
    assign bus.im_addr  = im_addr_q;
    assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);
    assign err          = err_q;
    assign count        = count_q;

    // Pack the presented field set according to its opcode format.
    always_comb begin
        word  = 16'h0000;
        legal = 1'b1;
        case (bus.op)
            OP_ADD, OP_ADDZ, OP_SUB, OP_AND, OP_NOR: word = {bus.op, bus.rd, bus.rs, bus.rt};
            OP_SLL, OP_SRL, OP_SRA:                  word = {bus.op, bus.rd, bus.rs, bus.imm[3:0]};
            OP_LLB, OP_LHB:                          word = {bus.op, bus.rd, bus.imm[7:0]};
            OP_B:                                    word = {bus.op, bus.cond, bus.imm};
            OP_HLT:                                  word = {bus.op, 12'h000};
            default: begin
`ifdef INSTR_ENC_CHK_EN
                legal = 1'b0;
`else
                word  = {bus.op, bus.rd, bus.rs, bus.rt};
`endif
            end
        endcase
    end

    // Load sequencing: run until HLT is accepted, then drain the FIFO.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (accept && (bus.op == OP_HLT)) state_d = S_DRAIN;
            S_DRAIN: if (fifo_empty) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FIFO pointers/occupancy, write address, written count and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            fifo_cnt  <= 3'd0;
            im_addr_q <= 16'h0000;
            count_q   <= 16'h0000;
            err_q     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (load) begin
                im_addr_q <= base;
                count_q   <= 16'h0000;
                err_q     <= 1'b0;
            end else begin
                // Address wraps naturally at 16 bits.
                if (pop) begin
                    im_addr_q <= im_addr_q + 16'd1;
                    count_q   <= count_q + 16'd1;
                end
                if (accept && !legal) err_q <= 1'b1;
            end
        end
    end

    // FIFO storage; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= word;
    end
endmodule

// File: tb/tb_instr_enc.sv
// Directed self-checking bench for instr_enc.
// Drives inputs 1 ns after the rising edge, samples on the falling edge or 1 ns after rising.
// Memory writes are logged on the falling edge and compared against hand-computed queues.
module tb_instr_enc;
    localparam logic [3:0] ADD = 4'h0, ADDZ = 4'h1, SUB = 4'h2, AND_ = 4'h3, NOR = 4'h4;
    localparam logic [3:0] SLL = 4'h5, SRA = 4'h7, LHB = 4'hA, LLB = 4'hB, BR = 4'hC, HLT = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base;
    logic        busy, done, err;
    logic [15:0] count;
    int          tests = 0;
    int          fails = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    instr_enc_if bus();

    instr_enc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .base  (base),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .count (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Log every write that will retire on the next rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.im_we === 1'b1 && bus.im_rdy === 1'b1)
            got_q.push_back({bus.im_addr, bus.im_wdata});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] b);
        start = 1'b1;
        base  = b;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [3:0] rt, input logic [8:0] imm, input logic [2:0] cond);
        int n;
        bus.fld_vld = 1'b1;
        bus.op = op; bus.rd = rd; bus.rs = rs; bus.rt = rt; bus.imm = imm; bus.cond = cond;
        n = 0;
        @(negedge clk);
        while (bus.fld_rdy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", 32'd0, 32'd1);
        tick();
        bus.fld_vld = 1'b0;
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    // Wait for the write stream to go quiet, then compare logged writes with expectations.
    task automatic flush_check(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.im_we === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check({tag, "_drain_timeout"}, 32'd0, 32'd1);
        check({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fld_rdy"},  bus.fld_rdy,  0);
        check({tag, "_im_we"},    bus.im_we,    0);
        check({tag, "_im_addr"},  bus.im_addr,  0);
        check({tag, "_im_wdata"}, bus.im_wdata, 0);
        check({tag, "_busy"},     busy,         0);
        check({tag, "_done"},     done,         0);
        check({tag, "_err"},      err,          0);
        check({tag, "_count"},    count,        0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; base = 16'h0;
        bus.fld_vld = 1'b0; bus.im_rdy = 1'b0;
        bus.op = 4'h0; bus.rd = 4'h0; bus.rs = 4'h0; bus.rt = 4'h0; bus.imm = 9'h0; bus.cond = 3'h0;
        tick(); tick();
        check_reset_outputs("reset");

        // Basic ADD at base 0x0100
        rst_n = 1'b1;
        bus.im_rdy = 1'b1;
        tick();
        pulse_start(16'h0100);
        check("run_busy", busy, 1);
        check("run_fld_rdy", bus.fld_rdy, 1);
        check("run_addr", bus.im_addr, 16'h0100);
        send(ADD, 4'h1, 4'h2, 4'h3, 9'h0, 3'h0);
        check("add_latency_we", bus.im_we, 1);
        check("add_latency_wdata", bus.im_wdata, 16'h0123);
        expect_wr(16'h0100, 16'h0123);
        flush_check("add");
        check("add_count", count, 16'd1);

        // LLB ignores imm[8]; SRA uses imm[3:0]
        send(LLB, 4'h5, 4'h0, 4'h0, 9'h1A5, 3'h0);
        send(SRA, 4'h2, 4'h4, 4'h0, 9'h007, 3'h0);
        expect_wr(16'h0101, 16'hB5A5);
        expect_wr(16'h0102, 16'h7247);
        flush_check("llb_sra");
        check("llb_sra_count", count, 16'd3);

        // Backpressure: fill the FIFO with memory stalled, then release
        bus.im_rdy = 1'b0;
        send(ADD,  4'h1, 4'h2, 4'h3, 9'h0, 3'h0);
        send(SUB,  4'h2, 4'h3, 4'h4, 9'h0, 3'h0);
        send(AND_, 4'h3, 4'h4, 4'h5, 9'h0, 3'h0);
        send(NOR,  4'h4, 4'h5, 4'h6, 9'h0, 3'h0);
        check("full_fld_rdy", bus.fld_rdy, 0);
        check("full_im_we", bus.im_we, 1);
        bus.fld_vld = 1'b1;
        bus.op = ADDZ; bus.rd = 4'h5; bus.rs = 4'h6; bus.rt = 4'h7;
        tick(); tick();
        check("stall_fld_rdy", bus.fld_rdy, 0);
        check("stall_addr", bus.im_addr, 16'h0103);
        check("stall_count", count, 16'd3);
        bus.im_rdy = 1'b1;
        send(ADDZ, 4'h5, 4'h6, 4'h7, 9'h0, 3'h0);
        expect_wr(16'h0103, 16'h0123);
        expect_wr(16'h0104, 16'h2234);
        expect_wr(16'h0105, 16'h3345);
        expect_wr(16'h0106, 16'h4456);
        expect_wr(16'h0107, 16'h1567);
        flush_check("bp");
        check("bp_count", count, 16'd8);

        // Branch then HLT ends the load
        send(BR, 4'h0, 4'h0, 4'h0, 9'h1FF, 3'b010);
        send(HLT, 4'h0, 4'h0, 4'h0, 9'h0, 3'h0);
        check("drain_fld_rdy", bus.fld_rdy, 0);
        expect_wr(16'h0108, 16'hC5FF);
        expect_wr(16'h0109, 16'hF000);
        flush_check("b_hlt");
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        check("hlt_done", done, 1);
        check("hlt_busy", busy, 0);
        check("hlt_count", count, 16'd10);
        bus.fld_vld = 1'b1; bus.op = ADD;
        tick(); tick(); tick();
        check("done_fld_rdy", bus.fld_rdy, 0);
        check("done_im_we", bus.im_we, 0);
        check("done_nwrites", got_q.size(), 0);
        check("done_count", count, 16'd10);
        bus.fld_vld = 1'b0;

        // Address wrap from a fresh start out of DONE
        pulse_start(16'hFFFF);
        check("wrap_count_clr", count, 16'd0);
        check("wrap_addr", bus.im_addr, 16'hFFFF);
        send(SLL, 4'h1, 4'h2, 4'h0, 9'h1F5, 3'h0);
        send(LHB, 4'h3, 4'h0, 4'h0, 9'h0FE, 3'h0);
        expect_wr(16'hFFFF, 16'h5125);
        expect_wr(16'h0000, 16'hA3FE);
        flush_check("wrap");
        check("wrap_addr_after", bus.im_addr, 16'h0001);
        check("wrap_count", count, 16'd2);

        // Undefined opcode between two ADDs
        send(ADD, 4'hA, 4'hB, 4'hC, 9'h0, 3'h0);
        send(4'h9, 4'h7, 4'h8, 4'h9, 9'h0, 3'h0);
        send(ADD, 4'hD, 4'hE, 4'hF, 9'h0, 3'h0);
`ifdef INSTR_ENC_CHK_EN
        expect_wr(16'h0001, 16'h0ABC);
        expect_wr(16'h0002, 16'h0DEF);
        flush_check("illegal");
        check("illegal_err", err, 1);
        check("illegal_count", count, 16'd4);
`else
        expect_wr(16'h0001, 16'h0ABC);
        expect_wr(16'h0002, 16'h9789);
        expect_wr(16'h0003, 16'h0DEF);
        flush_check("other_op");
        check("other_op_err", err, 0);
        check("other_op_count", count, 16'd5);
`endif

        // Reset mid-load discards queued words
        bus.im_rdy = 1'b0;
        send(ADD, 4'h1, 4'h1, 4'h1, 9'h0, 3'h0);
        send(ADD, 4'h2, 4'h2, 4'h2, 9'h0, 3'h0);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        bus.im_rdy = 1'b1;
        tick(); tick();
        check("midreset_no_we", bus.im_we, 0);
        check("midreset_nwrites", got_q.size(), 0);
        pulse_start(16'h0200);
        send(HLT, 4'h0, 4'h0, 4'h0, 9'h0, 3'h0);
        expect_wr(16'h0200, 16'hF000);
        flush_check("post_reset");
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        check("post_reset_done", done, 1);
        check("post_reset_count", count, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
